// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file access controller.
// States, access direction codes and architectural register numbers.
package regfile_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_SRC   = 3'd1,
        RD_DST   = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RES = 3'd4,
        WB       = 3'd5
    } state_t;

    localparam logic        RF_READ  = 1'b0;
    localparam logic        RF_WRITE = 1'b1;
    localparam int unsigned PC_REG   = 7;
    localparam int unsigned SP_REG   = 6;
    localparam logic [15:0] SP_RESET = 16'h0800;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Sequences decode requests onto a single-port regfile, one access/cycle.
// Optional macro RF_PC_PROTECT_EN blocks PC write-back and adds wr_err.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RF_ADDR_W = 8,
    parameter int REG_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [REG_SEL_W-1:0] req_src,
    input  logic [REG_SEL_W-1:0] req_dst,
    input  logic                 req_rd_src,
    input  logic                 req_rd_dst,
    input  logic                 req_wb,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [DATA_W-1:0]    op_src_data,
    output logic [DATA_W-1:0]    op_dst_data,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [DATA_W-1:0]    res_data,
    output logic [RF_ADDR_W-1:0] rf_regnum,
    output logic                 rf_rw,
    output logic [DATA_W-1:0]    rf_datain,
    input  logic [DATA_W-1:0]    rf_dataout,
`ifdef RF_PC_PROTECT_EN
    output logic                 wr_err,
`endif
    output logic                 busy
);

    state_t st, nx;

    logic [REG_SEL_W-1:0] src_q;
    logic [REG_SEL_W-1:0] dst_q;
    logic                 rd_dst_q;
    logic                 wb_q;
    logic [REG_SEL_W-1:0] sel;

    // State register; reset drops any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= nx;
    end

    // Request latch, operand capture and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q       <= '0;
            dst_q       <= '0;
            rd_dst_q    <= 1'b0;
            wb_q        <= 1'b0;
            op_src_data <= '0;
            op_dst_data <= '0;
            rf_datain   <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (req_valid) begin
                        src_q       <= req_src;
                        dst_q       <= req_dst;
                        rd_dst_q    <= req_rd_dst;
                        wb_q        <= req_wb;
                        op_src_data <= '0;
                        op_dst_data <= '0;
                    end
                end
                RD_SRC:   op_src_data <= rf_dataout;
                RD_DST:   op_dst_data <= rf_dataout;
                WAIT_RES: if (res_valid) rf_datain <= res_data;
                default: ;
            endcase
        end
    end

    // Next-state and handshake/regfile control decode.
    always_comb begin
        nx        = st;
        req_ready = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        rf_rw     = RF_READ;
        sel       = '0;
`ifdef RF_PC_PROTECT_EN
        wr_err    = 1'b0;
`endif
        unique case (st)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_rd_src)      nx = RD_SRC;
                    else if (req_rd_dst) nx = RD_DST;
                    else                 nx = ISSUE;
                end
            end
            RD_SRC: begin
                sel = src_q;
                nx  = rd_dst_q ? RD_DST : ISSUE;
            end
            RD_DST: begin
                sel = dst_q;
                nx  = ISSUE;
            end
            ISSUE: begin
                op_valid = 1'b1;
                if (op_ready) nx = wb_q ? WAIT_RES : IDLE;
            end
            WAIT_RES: begin
                res_ready = 1'b1;
                if (res_valid) nx = WB;
            end
            WB: begin
                sel   = dst_q;
                rf_rw = RF_WRITE;
`ifdef RF_PC_PROTECT_EN
                if (dst_q == REG_SEL_W'(PC_REG)) begin
                    rf_rw  = RF_READ;
                    wr_err = 1'b1;
                end
`endif
                nx = IDLE;
            end
            default: nx = IDLE;
        endcase
    end

    assign rf_regnum = RF_ADDR_W'(sel);
    assign busy      = (st != IDLE);

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench with a transaction-level model of the controller.
// Define RF_PC_PROTECT_EN to exercise the PC write protection.
module tb_regfile_access_ctrl;

`ifdef RF_PC_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_src, req_dst;
    logic        req_rd_src, req_rd_dst, req_wb;
    logic        op_valid, op_ready;
    logic [15:0] op_src_data, op_dst_data;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [7:0]  rf_regnum;
    logic        rf_rw;
    logic [15:0] rf_datain, rf_dataout;
    logic        busy;
    logic        wr_err_s;
`ifdef RF_PC_PROTECT_EN
    logic        wr_err;
    assign wr_err_s = wr_err;
`else
    assign wr_err_s = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst),
        .req_rd_src(req_rd_src), .req_rd_dst(req_rd_dst),
        .req_wb(req_wb),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_src_data(op_src_data), .op_dst_data(op_dst_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data),
        .rf_regnum(rf_regnum), .rf_rw(rf_rw),
        .rf_datain(rf_datain), .rf_dataout(rf_dataout),
`ifdef RF_PC_PROTECT_EN
        .wr_err(wr_err),
`endif
        .busy(busy)
    );

    // Physical regfile seen by the DUT.
    logic [15:0] mem [8];
    assign rf_dataout = mem[rf_regnum[2:0]];
    always @(posedge clk) if (rf_rw) mem[rf_regnum[2:0]] <= rf_datain;

    // Transaction model: pending reads, then issue, wait, write-back.
    logic [15:0] gold [8];
    int          rdq[$];
    bit          m_issue, m_wait, m_wb, m_wbreq;
    logic [2:0]  m_dst;
    logic [15:0] m_se, m_de, m_res;

    function automatic bit m_idle();
        return rdq.size() == 0 && !m_issue && !m_wait && !m_wb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdq.delete();
            m_issue = 0; m_wait = 0; m_wb = 0; m_wbreq = 0;
            m_res = '0; m_se = '0; m_de = '0;
        end else if (m_wb) begin
            if (!(PROT && m_dst == 3'd7)) gold[m_dst] = m_res;
            m_wb = 0;
        end else if (rdq.size() != 0) begin
            void'(rdq.pop_front());
        end else if (m_issue) begin
            if (op_ready) begin
                m_issue = 0;
                m_wait  = m_wbreq;
            end
        end else if (m_wait) begin
            if (res_valid) begin
                m_res  = res_data;
                m_wait = 0;
                m_wb   = 1;
            end
        end else if (req_valid) begin
            m_se    = req_rd_src ? gold[req_src] : 16'h0;
            m_de    = req_rd_dst ? gold[req_dst] : 16'h0;
            m_dst   = req_dst;
            m_wbreq = req_wb;
            if (req_rd_src) rdq.push_back(int'(req_src));
            if (req_rd_dst) rdq.push_back(int'(req_dst));
            m_issue = 1;
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin : cmp
        bit e_idle, e_opv, e_acc, ok;
        int e_reg;
        if (rst_n) begin
            e_idle = m_idle();
            e_opv  = rdq.size() == 0 && m_issue;
            e_acc  = rdq.size() != 0 || m_wb;
            e_reg  = rdq.size() != 0 ? rdq[0] : int'(m_dst);
            ok = req_ready === e_idle && busy === !e_idle &&
                 op_valid === e_opv && res_ready === m_wait &&
                 rf_rw === (m_wb && !(PROT && m_dst == 3'd7)) &&
                 wr_err_s === (m_wb && PROT && m_dst == 3'd7) &&
                 rf_datain === m_res && rf_regnum[7:3] === 5'd0;
            if (e_acc) ok = ok && int'(rf_regnum) == e_reg;
            if (e_opv) ok = ok && op_src_data === m_se &&
                            op_dst_data === m_de;
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got rr=%b opv=%b resr=%b rw=%b reg=%0d din=%h src=%h dst=%h busy=%b err=%b want rr=%b opv=%b resr=%b wb=%b reg=%0d din=%h src=%h dst=%h",
                         $time, req_ready, op_valid, res_ready, rf_rw,
                         rf_regnum, rf_datain, op_src_data, op_dst_data,
                         busy, wr_err_s, e_idle, e_opv, m_wait, m_wb,
                         e_reg, m_res, m_se, m_de);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] s, input logic [2:0] d,
                       input logic rs, input logic rd, input logic w);
        req_valid = 1; req_src = s; req_dst = d;
        req_rd_src = rs; req_rd_dst = rd; req_wb = w;
    endtask

    // No-read write-back request up to the WB cycle.
    task automatic to_wb(input logic [2:0] d, input logic [15:0] v);
        req(3'd0, d, 0, 0, 1);
        tick();
        req_valid = 0;
        op_ready = 1;
        tick();
        op_ready = 0;
        res_valid = 1; res_data = v;
        tick();
        res_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        req_valid = 0; req_src = 0; req_dst = 0;
        req_rd_src = 0; req_rd_dst = 0; req_wb = 0;
        op_ready = 0; res_valid = 0; res_data = 0;
        for (int i = 0; i < 8; i++) begin
            mem[i]  = 16'h1000 + 16'(i);
            gold[i] = 16'h1000 + 16'(i);
        end
        mem[2] = 16'h1234; gold[2] = 16'h1234;
        mem[3] = 16'h00FF; gold[3] = 16'h00FF;
        mem[5] = 16'h5A5A; gold[5] = 16'h5A5A;
        mem[7] = 16'h0000; gold[7] = 16'h0000;
        #3;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rw", rf_rw, 0);
        chk("rst_regnum", rf_regnum, 0);
        chk("rst_opv", op_valid, 0);
        #9 rst_n = 1;
        tick();

        // Two reads then write-back.
        req(3'd2, 3'd3, 1, 1, 1);
        tick();
        req_valid = 0;
        chk("t1_rd_src_reg", rf_regnum, 2);
        tick();
        chk("t1_rd_dst_reg", rf_regnum, 3);
        tick();
        chk("t1_opv", op_valid, 1);
        chk("t1_src", op_src_data, 16'h1234);
        chk("t1_dst", op_dst_data, 16'h00FF);
        op_ready = 1;
        tick();
        op_ready = 0;
        chk("t1_res_ready", res_ready, 1);
        res_valid = 1; res_data = 16'hABCD;
        tick();
        res_valid = 0;
        chk("t1_wb_rw", rf_rw, 1);
        chk("t1_wb_reg", rf_regnum, 3);
        chk("t1_wb_data", rf_datain, 16'hABCD);
        tick();
        chk("t1_rw_drop", rf_rw, 0);
        chk("t1_mem3", mem[3], 16'hABCD);
        chk("t1_gold3", gold[3], 16'hABCD);

        // No reads, no write-back.
        req(3'd1, 3'd4, 0, 0, 0);
        tick();
        req_valid = 0;
        chk("t2_opv", op_valid, 1);
        chk("t2_src0", op_src_data, 0);
        chk("t2_dst0", op_dst_data, 0);
        op_ready = 1;
        tick();
        op_ready = 0;
        chk("t2_idle", req_ready, 1);

        // Stall in ISSUE with a second request and early result waiting.
        req(3'd5, 3'd0, 1, 0, 0);
        tick();
        tick();
        req(3'd5, 3'd5, 1, 1, 0);
        res_valid = 1; res_data = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_opv", op_valid, 1);
            chk("t3_hold_src", op_src_data, 16'h5A5A);
            chk("t3_hold_rr", req_ready, 0);
            if (i == 4) op_ready = 1;
            tick();
        end
        op_ready = 0;
        res_valid = 0;
        chk("t3_back_idle", busy, 0);
        tick();
        req_valid = 0;
        chk("t6_rd1", rf_regnum, 5);
        tick();
        chk("t6_rd2", rf_regnum, 5);
        tick();
        chk("t6_src", op_src_data, 16'h5A5A);
        chk("t6_dst", op_dst_data, 16'h5A5A);
        op_ready = 1;
        tick();
        op_ready = 0;

        // Reset in the middle of a WB cycle.
        to_wb(3'd4, 16'hBEEF);
        chk("t4_in_wb", rf_rw, 1);
        #2 rst_n = 0;
        #1;
        chk("t4_rw_async", rf_rw, 0);
        chk("t4_busy", busy, 0);
        chk("t4_rr", req_ready, 1);
        chk("t4_din", rf_datain, 0);
        chk("t4_regnum", rf_regnum, 0);
        tick();
        tick();
        rst_n = 1;
        chk("t4_mem4", mem[4], 16'h1004);
        tick();

        // PC write-back, then SP write-back.
        to_wb(3'd7, 16'h0100);
        chk("t5_pc_rw", rf_rw, PROT ? 32'd0 : 32'd1);
`ifdef RF_PC_PROTECT_EN
        chk("t5_wr_err", wr_err, 1);
`endif
        tick();
        chk("t5_mem7", mem[7], PROT ? 32'h0000 : 32'h0100);
`ifdef RF_PC_PROTECT_EN
        chk("t5_wr_err_end", wr_err, 0);
`endif
        to_wb(3'd6, 16'h0900);
        chk("t5_sp_rw", rf_rw, 1);
        tick();
        chk("t5_mem6", mem[6], 16'h0900);

        for (int i = 0; i < 8; i++) chk("final_mem", mem[i], gold[i]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
